// File: rtl/mtm_alu_sin_deser.sv
// Serial-input stage of the ALU: deserializes 11-bit frames into {B, A, OP},
// checks CRC4 and opcode, and holds one record for the core via valid/ready.
module mtm_alu_sin_deser #(
  parameter int N_DATA = 8,
  parameter bit CRC_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_op,
  output logic [2:0]  out_err,
  output logic        overrun
);

  localparam int CW = $clog2(N_DATA + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(N_DATA);
  localparam logic [CW-1:0] CNT_SAT  = CW'(N_DATA + 1);

  typedef enum logic [2:0] {IDLE, TYPE, DATA, STOP, WAIT_HI} state_t;

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt;
  logic          is_cmd;
  logic [6:0]    cmd;
  logic [63:0]   data_q;
  logic [CW-1:0] cnt;
  logic          ferr;

  logic          data_done, pkt_done, frame_bad;
  logic [2:0]    op;
  logic [3:0]    crc_rx, crc_calc;
  logic          op_ok, e_data, e_crc, e_op;

  // LFSR for x^4+x+1, init 0, MSB first
  function automatic logic [3:0] crc4(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!sin) state_nxt = TYPE;
      TYPE:    state_nxt = DATA;
      DATA:    if (bit_cnt == 3'd7) state_nxt = STOP;
      STOP:    state_nxt = sin ? IDLE : WAIT_HI;
      WAIT_HI: if (sin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_done = (state == STOP) && sin && !is_cmd;
    pkt_done  = (state == STOP) && sin && is_cmd;
    frame_bad = (state == STOP) && !sin;
  end

  // Data bits shift straight into the operand register; the cmd shifter keeps
  // only the low 7 bits, so the unused MSB of the command byte falls off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      is_cmd  <= 1'b0;
      cmd     <= '0;
      data_q  <= '0;
    end else if (state == TYPE) begin
      is_cmd  <= sin;
      bit_cnt <= '0;
    end else if (state == DATA) begin
      bit_cnt <= bit_cnt + 3'd1;
      cmd     <= {cmd[5:0], sin};
      if (!is_cmd && cnt < CNT_FULL) data_q <= {data_q[62:0], sin};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      ferr <= 1'b0;
    end else if (pkt_done) begin
      cnt  <= '0;
      ferr <= 1'b0;
    end else begin
      if (data_done && cnt != CNT_SAT) cnt <= cnt + 1'b1;
      if (frame_bad) ferr <= 1'b1;
    end
  end

  always_comb begin
    op       = cmd[6:4];
    crc_rx   = cmd[3:0];
    crc_calc = crc4({data_q, 1'b1, op});
    op_ok    = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101);
    e_data   = (cnt != CNT_FULL) || ferr;
    e_crc    = !e_data && CRC_EN && (crc_rx != crc_calc);
    e_op     = !e_data && !e_crc && !op_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_op    <= '0;
      out_err   <= '0;
      overrun   <= 1'b0;
    end else if (pkt_done) begin
      out_valid <= 1'b1;
      out_a     <= e_data ? 32'd0 : data_q[31:0];
      out_b     <= e_data ? 32'd0 : data_q[63:32];
      out_op    <= e_data ? 3'd0 : op;
      out_err   <= {e_data, e_crc, e_op};
      overrun   <= out_valid && !out_ready;
    end else begin
      overrun <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end

endmodule
